// File: rtl/chip2chip_master_control.sv
// Master side of the 3-bit request/ack chip-to-chip link.
// Latches a value on send, lights a notice delay, then handshakes the value across to the slave.
module chip2chip_master_control #(
  parameter int DELAY_CYCLES   = 100000000,
  parameter int HOLD_CYCLES    = 100000000,
  parameter int TIMEOUT_CYCLES = 500000000,
  parameter int CNT_W          = 29
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [2:0] data_in,
  input  logic       ack,
  output logic       request,
  output logic       valid,
  output logic [2:0] data_out,
  output logic       notice,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    NOTICE  = 3'd1,
    REQ     = 3'd2,
    SEND    = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       data_reg, data_next;
  logic             err_next;
  logic             ack_meta, ack_s;

  // ack comes from another board: two flops before anything looks at it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      ack_meta <= ack;
      ack_s    <= ack_meta;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    data_next  = data_reg;
    err_next   = err;
    case (state_reg)
      IDLE: begin
        if (send) begin
          data_next  = data_in;
          err_next   = 1'b0;
          cnt_next   = '0;
          state_next = NOTICE;
        end
      end
      NOTICE: begin
        if (cnt_reg == DELAY_LAST) begin
          cnt_next   = '0;
          state_next = REQ;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      REQ: begin
        // a late ack still beats the timeout on the same cycle
        if (ack_s) begin
          cnt_next   = '0;
          state_next = SEND;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          err_next   = 1'b1;
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      SEND: begin
        if (cnt_reg == HOLD_LAST) begin
          cnt_next   = '0;
          state_next = RELEASE;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      RELEASE: begin
        if (!ack_s) state_next = IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they move with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      data_reg  <= 3'd0;
      err       <= 1'b0;
      request   <= 1'b0;
      valid     <= 1'b0;
      data_out  <= 3'd0;
      notice    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      data_reg  <= data_next;
      err       <= err_next;
      request   <= (state_next == REQ);
      valid     <= (state_next == SEND);
      data_out  <= (state_next == SEND) ? data_next : 3'd0;
      notice    <= (state_next == NOTICE);
      busy      <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_chip2chip_master_control.sv
// Bench for chip2chip_master_control: hand-made vector table, directed corner cases,
// and random traffic checked against a countdown/queue reference model.
module tb_chip2chip_master_control;

  localparam int DELAY   = 4;
  localparam int HOLD    = 3;
  localparam int TIMEOUT = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       send = 1'b0;
  logic [2:0] data_in = 3'd0;
  logic       ack = 1'b0;
  logic       request, valid, notice, busy, err;
  logic [2:0] data_out;

  int total = 0;
  int bad   = 0;

  chip2chip_master_control #(
    .DELAY_CYCLES(DELAY), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TIMEOUT), .CNT_W(5)
  ) dut (
    .clk(clk), .rst(rst), .send(send), .data_in(data_in), .ack(ack),
    .request(request), .valid(valid), .data_out(data_out),
    .notice(notice), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // reference model: phase plus remaining-cycle countdown, ack seen two edges late
  typedef enum int {P_IDLE, P_WAIT, P_ASK, P_DRIVE, P_DRAIN} phase_t;
  phase_t     ph;
  int         left;
  logic [2:0] m_data;
  logic       m_err;
  logic       ackq[$];

  int   notice_cycles;
  int   notice_rises;
  logic prev_notice;

  function automatic logic [7:0] obs();
    return {notice, request, valid, data_out, busy, err};
  endfunction

  function automatic logic [7:0] m_exp();
    return {ph == P_WAIT, ph == P_ASK, ph == P_DRIVE,
            (ph == P_DRIVE) ? m_data : 3'd0, ph != P_IDLE, m_err};
  endfunction

  task automatic m_reset();
    ph = P_IDLE; left = 0; m_data = 3'd0; m_err = 1'b0;
    ackq = '{1'b0, 1'b0};
  endtask

  task automatic m_tick(input logic s, input logic [2:0] d, input logic a);
    logic as;
    as = ackq[0];
    void'(ackq.pop_front());
    ackq.push_back(a);
    case (ph)
      P_IDLE:  if (s) begin m_data = d; m_err = 1'b0; ph = P_WAIT; left = DELAY; end
      P_WAIT:  begin left--; if (left == 0) begin ph = P_ASK; left = TIMEOUT; end end
      P_ASK:   if (as) begin ph = P_DRIVE; left = HOLD; end
               else begin left--; if (left == 0) begin m_err = 1'b1; ph = P_IDLE; end end
      P_DRIVE: begin left--; if (left == 0) ph = P_DRAIN; end
      P_DRAIN: if (!as) ph = P_IDLE;
      default: ph = P_IDLE;
    endcase
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, req, $time);
    end
  endtask

  task automatic step(input logic s, input logic [2:0] d, input logic a);
    send = s; data_in = d; ack = a;
    @(posedge clk);
    m_tick(s, d, a);
    #1;
    check("model", obs(), m_exp());
    if (notice) notice_cycles++;
    if (notice && !prev_notice) notice_rises++;
    prev_notice = notice;
  endtask

  task automatic do_reset();
    rst = 1'b1; send = 1'b0; ack = 1'b0; data_in = 3'd0;
    #1;
    m_reset();
    check("reset_outputs", obs(), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    prev_notice = 1'b0; notice_cycles = 0; notice_rises = 0;
  endtask

  task automatic transfer(input logic [2:0] d, input string tag);
    int n;
    step(1'b1, d, 1'b0);
    n = 0; while (!request && n < 10) begin step(1'b0, ~d, 1'b0); n++; end
    check({tag, "_req_rise"}, {7'd0, request}, 8'd1);
    n = 0; while (!valid && n < 6) begin step(1'b0, ~d, 1'b1); n++; end
    check({tag, "_valid_rise"}, {7'd0, valid}, 8'd1);
    n = 0;
    while (valid && n < 6) begin
      check({tag, "_data"}, {5'd0, data_out}, {5'd0, d});
      step(1'b0, ~d, 1'b1); n++;
    end
    check({tag, "_hold_len"}, 8'(n), 8'(HOLD));
    n = 0; while (busy && n < 6) begin step(1'b0, ~d, 1'b0); n++; end
    check({tag, "_idle"}, {7'd0, busy}, 8'd0);
  endtask

  typedef struct {
    logic       s;
    logic [2:0] d;
    logic       a;
    logic [7:0] exp;  // {notice, request, valid, data_out, busy, err}
  } vec_t;
  vec_t tbl[20];

  initial begin
    int n, rq, vseen;
    logic a_r;

    // nominal transfer, values worked out by hand edge by edge
    for (int i = 0; i < 20; i++) begin
      tbl[i].s = (i == 0);
      tbl[i].d = (i == 0) ? 3'b101 : 3'b010;
      tbl[i].a = (i >= 9 && i <= 15);
      if (i < 4)       tbl[i].exp = 8'b100_000_10;
      else if (i < 11) tbl[i].exp = 8'b010_000_10;
      else if (i < 14) tbl[i].exp = 8'b001_101_10;
      else if (i < 18) tbl[i].exp = 8'b000_000_10;
      else             tbl[i].exp = 8'b000_000_00;
    end

    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].s, tbl[i].d, tbl[i].a);
      check($sformatf("nominal_vec%0d", i), obs(), tbl[i].exp);
    end
    $display("scenario nominal: vectors=20");

    // ack timeout
    step(1'b1, 3'b011, 1'b0);
    rq = 0; vseen = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 3'($urandom_range(0, 7)), 1'b0);
      if (request) rq++;
      if (valid) vseen++;
    end
    check("timeout_req_len", 8'(rq), 8'(TIMEOUT));
    check("timeout_state", {5'd0, err, busy, valid}, 8'b100);
    check("timeout_no_valid", 8'(vseen), 8'd0);
    step(1'b1, 3'b100, 1'b0);
    check("timeout_err_clear", {7'd0, err}, 8'd0);
    $display("scenario timeout: request_cycles=%0d", rq);

    // busy filtering
    do_reset();
    step(1'b1, 3'b001, 1'b0);
    step(1'b0, 3'b001, 1'b0);
    step(1'b1, 3'b110, 1'b0);
    n = 0; while (!request && n < 10) begin step(1'b0, 3'b110, 1'b0); n++; end
    n = 0; while (!valid && n < 6) begin step(1'b0, 3'b110, 1'b1); n++; end
    check("filter_data1", {4'd0, valid, data_out}, 8'b1001);
    step(1'b1, 3'b110, 1'b1);
    check("filter_data2", {4'd0, valid, data_out}, 8'b1001);
    n = 0; while (valid && n < 6) begin step(1'b0, 3'b110, 1'b1); n++; end
    n = 0; while (busy && n < 6) begin step(1'b0, 3'b110, 1'b0); n++; end
    for (int i = 0; i < 6; i++) step(1'b0, 3'b110, 1'b0);
    check("filter_one_transfer", 8'(notice_rises), 8'd1);
    $display("scenario busy_filter: transfers=%0d", notice_rises);

    // late ack release
    do_reset();
    step(1'b1, 3'b101, 1'b0);
    n = 0; while (!request && n < 10) begin step(1'b0, 3'b000, 1'b0); n++; end
    n = 0; while (!valid && n < 6) begin step(1'b0, 3'b000, 1'b1); n++; end
    n = 0; while (valid && n < 6) begin step(1'b0, 3'b000, 1'b1); n++; end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 3'b000, 1'b1);
      check("late_release_hold", obs(), 8'b000_000_10);
    end
    step(1'b0, 3'b000, 1'b0); check("late_release_b1", {7'd0, busy}, 8'd1);
    step(1'b0, 3'b000, 1'b0); check("late_release_b2", {7'd0, busy}, 8'd1);
    step(1'b0, 3'b000, 1'b0); check("late_release_idle", {7'd0, busy}, 8'd0);
    $display("scenario late_ack: done");

    // async reset during SEND, then a fresh transfer
    do_reset();
    step(1'b1, 3'b010, 1'b0);
    n = 0; while (!request && n < 10) begin step(1'b0, 3'b010, 1'b0); n++; end
    n = 0; while (!valid && n < 6) begin step(1'b0, 3'b010, 1'b1); n++; end
    check("midrst_in_send", {7'd0, valid}, 8'd1);
    #2;
    do_reset();
    transfer(3'b111, "post_rst");
    $display("scenario reset_mid_send: done");

    // one-cycle ack glitch during NOTICE
    do_reset();
    step(1'b1, 3'b110, 1'b0);
    step(1'b0, 3'b110, 1'b1);
    n = 0; while (!request && n < 12) begin step(1'b0, 3'b110, 1'b0); n++; end
    check("glitch_notice_len", 8'(notice_cycles), 8'(DELAY));
    for (int i = 0; i < 8; i++) step(1'b0, 3'b110, 1'b0);
    check("glitch_req_hold", {6'd0, request, valid}, 8'b10);
    $display("scenario ack_glitch: notice_cycles=%0d", notice_cycles);

    // random traffic against the model
    do_reset();
    a_r = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) a_r = ~a_r;
      step($urandom_range(0, 5) == 0, 3'($urandom_range(0, 7)), a_r);
    end
    $display("scenario random: cycles=500");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
